shift_serializer: RTL and testbench

- Downstream stage of the 8-bit rotate/shift register. Takes its parallel result word and sends it out on one line as a framed serial stream: start bit, WIDTH data bits, stop bit(s).
- Uses a valid/ready handshake with a programmable bit period.
- Drives the board's serial output or LED probe line.

---
 rtl/shift_serializer_pkg.sv | 7 +
 rtl/shift_serializer_if.sv | 12 +
 rtl/shift_serializer_bit_timer.sv | 21 ++
 rtl/shift_serializer.sv | 96 +++++++++
 tb/tb_shift_serializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_serializer_pkg.sv
// shift_pkg: FSM states and serial line levels shared by the serializer.
package shift_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/shift_serializer_if.sv
// shift_serializer_if: parallel-word handshake and serial line outputs.
interface shift_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] Din;
  logic valid;
  logic lsb_first;
  logic ready;
  logic Sout;
  logic busy;
  logic done;
  modport master (output Din, valid, lsb_first, input ready, Sout, busy, done);
  modport slave (input Din, valid, lsb_first, output ready, Sout, busy, done);
endinterface

// File: rtl/shift_serializer_bit_timer.sv
// bit_timer: counts DIV cycles per serial bit; tick_next lets the caller register outputs one cycle ahead.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic tick_next
);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == TW'(DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + TW'(1);
    tick_next = cnt_d == TW'(DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: sends a parallel word as start bit, WIDTH data bits and stop bit(s).
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV = 4,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  shift_serializer_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [IW-1:0] idx_q, idx_d;
  logic [0:0] sb_q, sb_d;
  logic lsb_q, lsb_d, sout_q, sout_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic accept, tick, tick_next, first_bit, final_next;
  bit_timer #(.DIV(DIV)) u_timer (.clk(clk), .rst_n(rst_n), .clr(accept), .tick(tick), .tick_next(tick_next));
  always_comb begin
    accept = bus.valid && ready_q;
    first_bit = lsb_q ? sr_q[0] : sr_q[WIDTH-1];
    shifted = lsb_q ? sr_q >> 1 : sr_q << 1;
    state_d = state_q;
    sr_d = sr_q;
    lsb_d = lsb_q;
    idx_d = idx_q;
    sb_d = sb_q;
    sout_d = sout_q;
    case (state_q)
      S_IDLE: ;
      S_START:
        if (tick) begin
          state_d = S_DATA;
          sout_d = first_bit;
          sr_d = shifted;
          idx_d = '0;
        end
      S_DATA:
        if (tick && idx_q == IW'(WIDTH - 1)) begin
          state_d = S_STOP;
          sout_d = STOP_BIT;
          sb_d = '0;
        end else if (tick) begin
          idx_d = idx_q + IW'(1);
          sout_d = first_bit;
          sr_d = shifted;
        end
      S_STOP:
        if (tick && sb_q == 1'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          sb_d = '0;
        end else if (tick) sb_d = sb_q + 1'b1;
    endcase
    // ready is raised during the last stop cycle so a held valid starts the next frame with no gap
    if (accept) begin
      state_d = S_START;
      sr_d = bus.Din;
      lsb_d = bus.lsb_first;
      idx_d = '0;
      sb_d = '0;
      sout_d = START_BIT;
    end
    final_next = state_d == S_STOP && sb_d == 1'(STOP_BITS - 1) && tick_next;
    done_d = final_next;
    ready_d = state_d == S_IDLE || final_next;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q <= '0;
      lsb_q <= 1'b0;
      idx_q <= '0;
      sb_q <= '0;
      sout_q <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      lsb_q <= lsb_d;
      idx_q <= idx_d;
      sb_q <= sb_d;
      sout_q <= sout_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.ready = ready_q;
  assign bus.Sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: scoreboard bench for DIV=4/STOP=1 and DIV=1/STOP=2 serializers.
module tb_shift_serializer;
  logic clk, rst_n;
  int n_cmp, n_err;
  logic q0[$];
  logic q1[$];
  shift_serializer_if #(.WIDTH(8)) b0 ();
  shift_serializer_if #(.WIDTH(8)) b1 ();
  shift_serializer #(.WIDTH(8), .DIV(4), .STOP_BITS(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  shift_serializer #(.WIDTH(8), .DIV(1), .STOP_BITS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_frame(input int d, input logic [7:0] w, input logic lsb);
    logic f[$];
    int div, stop;
    div = d ? 1 : 4;
    stop = d ? 2 : 1;
    f.push_back(1'b0);
    for (int i = 0; i < 8; i++) f.push_back(lsb ? w[i] : w[7-i]);
    for (int i = 0; i < stop; i++) f.push_back(1'b1);
    foreach (f[i])
      for (int j = 0; j < div; j++)
        if (d) q1.push_back(f[i]);
        else q0.push_back(f[i]);
  endtask

  task automatic start0(input logic [7:0] w, input logic lsb);
    @(negedge clk);
    b0.Din = w;
    b0.lsb_first = lsb;
    b0.valid = 1'b1;
    push_frame(0, w, lsb);
    @(posedge clk);
    #1 b0.valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if ({b0.Sout, b0.ready, b0.busy, b0.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset0 {Sout,ready,busy,done} got %b expected 1100", {b0.Sout, b0.ready, b0.busy, b0.done});
    end
    if ({b1.Sout, b1.ready, b1.busy, b1.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset1 {Sout,ready,busy,done} got %b expected 1100", {b1.Sout, b1.ready, b1.busy, b1.done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({b0.Sout, b0.ready, b0.busy, b0.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL idle0 {Sout,ready,busy,done} got %b expected 1100", {b0.Sout, b0.ready, b0.busy, b0.done});
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] w, input logic lsb);
    logic e;
    start0(w, lsb);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = q0.pop_front();
      n_cmp += 3;
      if (b0.Sout !== e) begin
        n_err++;
        $display("FAIL %s Sout cycle %0d got %b expected %b", name, k, b0.Sout, e);
      end
      if (b0.done !== (k == 40)) begin
        n_err++;
        $display("FAIL %s done cycle %0d got %b expected %b", name, k, b0.done, k == 40);
      end
      if (b0.ready !== (k == 40) || b0.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s ready/busy cycle %0d got %b/%b expected %b/1", name, k, b0.ready, b0.busy, k == 40);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({b0.Sout, b0.ready, b0.busy, b0.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL %s idle after frame got %b expected 1100", name, {b0.Sout, b0.ready, b0.busy, b0.done});
    end
  endtask

  task automatic test_back_to_back;
    logic e;
    @(negedge clk);
    b0.Din = 8'h81;
    b0.lsb_first = 1'b1;
    b0.valid = 1'b1;
    push_frame(0, 8'h81, 1'b1);
    push_frame(0, 8'h7E, 1'b1);
    @(posedge clk);
    #1 b0.Din = 8'h7E;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      e = q0.pop_front();
      n_cmp += 2;
      if (b0.Sout !== e) begin
        n_err++;
        $display("FAIL b2b Sout cycle %0d got %b expected %b", k, b0.Sout, e);
      end
      if (b0.done !== (k == 40 || k == 80)) begin
        n_err++;
        $display("FAIL b2b done cycle %0d got %b expected %b", k, b0.done, k == 40 || k == 80);
      end
      if (k == 41) begin
        b0.valid = 1'b0;
        n_cmp++;
        if (b0.busy !== 1'b1 || b0.ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b second start busy/ready got %b/%b expected 1/0", b0.busy, b0.ready);
        end
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic e;
    start0(8'h00, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = q0.pop_front();
      n_cmp += 2;
      if (b0.Sout !== e) begin
        n_err++;
        $display("FAIL ignore Sout cycle %0d got %b expected %b", k, b0.Sout, e);
      end
      if (b0.ready !== (k == 40)) begin
        n_err++;
        $display("FAIL ignore ready cycle %0d got %b expected %b", k, b0.ready, k == 40);
      end
      b0.Din = 8'hFF;
      b0.lsb_first = k[0];
      b0.valid = (k >= 3 && k <= 30);
    end
    b0.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic e;
    start0(8'h0F, 1'b1);
    for (int k = 1; k < 18; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b0.Sout, b0.ready, b0.busy, b0.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_mid async got %b expected 1100", {b0.Sout, b0.ready, b0.busy, b0.done});
    end
    q0.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (b0.done !== 1'b0 || b0.Sout !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid hold done/Sout got %b/%b expected 0/1", b0.done, b0.Sout);
      end
    end
    rst_n = 1'b1;
    start0(8'h3C, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = q0.pop_front();
      n_cmp++;
      if (b0.Sout !== e) begin
        n_err++;
        $display("FAIL reset_mid resend Sout cycle %0d got %b expected %b", k, b0.Sout, e);
      end
    end
  endtask

  task automatic test_div1;
    logic e;
    @(negedge clk);
    b1.Din = 8'hA0;
    b1.lsb_first = 1'b0;
    b1.valid = 1'b1;
    push_frame(1, 8'hA0, 1'b0);
    @(posedge clk);
    #1 b1.valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      e = q1.pop_front();
      n_cmp += 3;
      if (b1.Sout !== e) begin
        n_err++;
        $display("FAIL div1 Sout cycle %0d got %b expected %b", k, b1.Sout, e);
      end
      if (b1.done !== (k == 11)) begin
        n_err++;
        $display("FAIL div1 done cycle %0d got %b expected %b", k, b1.done, k == 11);
      end
      if (b1.ready !== (k == 11)) begin
        n_err++;
        $display("FAIL div1 ready cycle %0d got %b expected %b", k, b1.ready, k == 11);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({b1.Sout, b1.ready, b1.busy, b1.done} !== 4'b1100) begin
      n_err++;
      $display("FAIL div1 idle got %b expected 1100", {b1.Sout, b1.ready, b1.busy, b1.done});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    b0.Din = '0;
    b0.valid = 1'b0;
    b0.lsb_first = 1'b0;
    b1.Din = '0;
    b1.valid = 1'b0;
    b1.lsb_first = 1'b0;
    test_reset();
    test_frame("lsb_first", 8'h0F, 1'b1);
    test_frame("msb_first", 8'h0F, 1'b0);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
